// File: rtl/beat_tone_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | beat_tone_detector: locks onto C#/G# metronome beeps on tone_in, strobes  |
// | each beep onset and shows the beat number on a 7-segment display.        |
// | Optional: BEAT_INTERVAL_MEAS_EN adds an onset-to-onset interval counter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module beat_tone_detector #(
    parameter int C_PERIOD = 97408,
    parameter int G_PERIOD = 65014,
    parameter int TOL      = 2048,
    parameter int CONFIRM  = 4,
    parameter int SILENCE  = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        beat_pulse,
    output logic        accent,
    output logic        locked,
    output logic [1:0]  tone_class,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic [26:0] onset_interval
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_TONE = 2'd2
    } state_t;

    localparam logic [1:0]  c_cls_none = 2'b00;
    localparam logic [1:0]  c_cls_c    = 2'b01;
    localparam logic [1:0]  c_cls_g    = 2'b10;
    localparam int          c_cnt_w    = $clog2(CONFIRM + 1);
    localparam int          c_sil_w    = $clog2(SILENCE + 1);
    localparam logic [16:0] c_c_lo     = 17'(C_PERIOD - TOL);
    localparam logic [16:0] c_c_hi     = 17'(C_PERIOD + TOL);
    localparam logic [16:0] c_g_lo     = 17'(G_PERIOD - TOL);
    localparam logic [16:0] c_g_hi     = 17'(G_PERIOD + TOL);
    localparam logic [16:0] c_per_max  = '1;
    localparam logic [c_cnt_w-1:0] c_confirm = c_cnt_w'(CONFIRM);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_sil_w-1:0] c_sil_max = c_sil_w'(SILENCE);
    localparam logic [c_sil_w-1:0] c_sil_lim = c_sil_w'(SILENCE - 1);
    localparam logic [c_sil_w-1:0] c_sil_one = c_sil_w'(1);

    logic [2:0]         sync_q, sync_d;
    logic [16:0]        period_q, period_d;
    logic [c_sil_w-1:0] sil_q, sil_d;
    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [1:0]         cls_q, cls_d;
    logic [1:0]         tone_class_q, tone_class_d;
    logic [3:0]         beat_num_q, beat_num_d;
    logic               beat_pulse_q, beat_pulse_d;
    logic               accent_q, accent_d;
    logic               w_rise;
    logic               w_timeout;
    logic [1:0]         w_meas;
    logic [6:0]         w_seg;

    // sync_q[1] is the synchronized sample; sync_q[2] is its one-cycle delay
    assign w_rise    = sync_q[1] & ~sync_q[2];
    assign w_timeout = ~w_rise && (sil_q >= c_sil_lim);

    always_comb begin
        sync_d   = {sync_q[1:0], tone_in};
        period_d = w_rise ? 17'd1 : ((period_q == c_per_max) ? period_q : period_q + 17'd1);
        sil_d    = w_rise ? c_sil_one : ((sil_q == c_sil_max) ? sil_q : sil_q + c_sil_one);
        if (period_q >= c_c_lo && period_q <= c_c_hi) begin
            w_meas = c_cls_c;
        end else if (period_q >= c_g_lo && period_q <= c_g_hi) begin
            w_meas = c_cls_g;
        end else begin
            w_meas = c_cls_none;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cls_d        = cls_q;
        tone_class_d = tone_class_q;
        beat_num_d   = beat_num_q;
        beat_pulse_d = 1'b0;
        accent_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    state_d = ST_ACQ;
                    cnt_d   = '0;
                    cls_d   = c_cls_none;
                end
            end
            ST_ACQ: begin
                if (w_rise) begin
                    if (w_meas == c_cls_none) begin
                        cnt_d = '0;
                        cls_d = c_cls_none;
                    end else if (w_meas == cls_q) begin
                        cnt_d = cnt_q + c_cnt_one;
                    end else begin
                        cnt_d = c_cnt_one;
                        cls_d = w_meas;
                    end
                    if (cnt_d == c_confirm) begin
                        state_d      = ST_TONE;
                        cnt_d        = '0;
                        beat_pulse_d = 1'b1;
                        accent_d     = (w_meas == c_cls_g);
                        tone_class_d = w_meas;
                        beat_num_d   = (beat_num_q >= 4'd8) ? 4'd1 : beat_num_q + 4'd1;
                    end
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_TONE: begin
                // cnt_q counts consecutive mismatching periods while locked
                if (w_rise) begin
                    if (w_meas != c_cls_none && w_meas == tone_class_q) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                    if (cnt_d == c_confirm) begin
                        state_d = ST_ACQ;
                        cnt_d   = '0;
                        cls_d   = c_cls_none;
                    end
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            period_q     <= '0;
            sil_q        <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cls_q        <= c_cls_none;
            tone_class_q <= c_cls_none;
            beat_num_q   <= '0;
            beat_pulse_q <= 1'b0;
            accent_q     <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            period_q     <= period_d;
            sil_q        <= sil_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cls_q        <= cls_d;
            tone_class_q <= tone_class_d;
            beat_num_q   <= beat_num_d;
            beat_pulse_q <= beat_pulse_d;
            accent_q     <= accent_d;
        end
    end

    always_comb begin
        case (beat_num_q)
            4'd0:    w_seg = 7'b1111110;
            4'd1:    w_seg = 7'b0110000;
            4'd2:    w_seg = 7'b1101101;
            4'd3:    w_seg = 7'b1111001;
            4'd4:    w_seg = 7'b0110011;
            4'd5:    w_seg = 7'b1011011;
            4'd6:    w_seg = 7'b1011111;
            4'd7:    w_seg = 7'b1110000;
            4'd8:    w_seg = 7'b1111111;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign {a, b, c, d, e, f, g} = w_seg;
    assign beat_pulse = beat_pulse_q;
    assign accent     = accent_q;
    assign locked     = (state_q == ST_TONE);
    assign tone_class = tone_class_q;

`ifdef BEAT_INTERVAL_MEAS_EN
    logic [26:0] ival_cnt_q, ival_cnt_d;
    logic [26:0] ival_q, ival_d;
    logic        seen_q, seen_d;

    // the very first onset has no predecessor, so it reports 0
    always_comb begin
        ival_cnt_d = (ival_cnt_q == 27'h7FFFFFF) ? ival_cnt_q : ival_cnt_q + 27'd1;
        ival_d     = ival_q;
        seen_d     = seen_q;
        if (beat_pulse_d) begin
            ival_d     = seen_q ? ival_cnt_q : 27'd0;
            ival_cnt_d = 27'd1;
            seen_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ival_cnt_q <= '0;
            ival_q     <= '0;
            seen_q     <= 1'b0;
        end else begin
            ival_cnt_q <= ival_cnt_d;
            ival_q     <= ival_d;
            seen_q     <= seen_d;
        end
    end

    assign onset_interval = ival_q;
`else
    assign onset_interval = '0;
`endif

endmodule
`default_nettype wire
